// File: rtl/io_bus_master.sv
// io_bus_master
//   Single-outstanding command/response master for a simple strobed
//   peripheral bus. A command is accepted in IDLE. Misaligned addresses
//   are answered with an error and never reach the bus. Aligned commands
//   produce a one-cycle bus_clk_en strobe. Reads then wait READ_LATENCY
//   cycles before sampling the responder's registered data.
//
// Parameters
//   READ_LATENCY  cycles from strobe to valid bus_data_read (1..7)
//   ADDR_W        byte-address width
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   cmd_*               command channel (valid/ready, write, address, wdata)
//   rsp_*               response channel (valid/ready, rdata, error)
//   bus_clk_en          one-cycle transfer strobe
//   bus_address         byte address to the responder
//   bus_data_write      write data to the responder
//   bus_wren            write enable, qualified by bus_clk_en
//   bus_data_read       registered read data from the responder
module io_bus_master #(
    parameter int READ_LATENCY = 1,
    parameter int ADDR_W       = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_address,
    input  logic [31:0]       cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_error,
    output logic              bus_clk_en,
    output logic [ADDR_W-1:0] bus_address,
    output logic [31:0]       bus_data_write,
    output logic              bus_wren,
    input  logic [31:0]       bus_data_read
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    // Counter reload: WAIT lasts READ_LATENCY cycles, the last one is lat_cnt==0.
    localparam logic [2:0] LAT_LAST = 3'(READ_LATENCY - 1);

    logic [1:0] state;
    logic [2:0] lat_cnt;
    logic       cap_write;

    assign cmd_ready = (state == S_IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            lat_cnt        <= 3'd0;
            cap_write      <= 1'b0;
            bus_clk_en     <= 1'b0;
            bus_wren       <= 1'b0;
            bus_address    <= '0;
            bus_data_write <= 32'd0;
            rsp_valid      <= 1'b0;
            rsp_rdata      <= 32'd0;
            rsp_error      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        cap_write <= cmd_write;
                        if (cmd_address[1:0] != 2'b00) begin
                            // Rejected before the bus: address/data registers keep old values.
                            state     <= S_RESP;
                            rsp_valid <= 1'b1;
                            rsp_error <= 1'b1;
                            rsp_rdata <= 32'd0;
                        end else begin
                            // The bus registers double as the captured address/data,
                            // so the strobe lines up with ISSUE.
                            state          <= S_ISSUE;
                            bus_clk_en     <= 1'b1;
                            bus_wren       <= cmd_write;
                            bus_address    <= cmd_address;
                            bus_data_write <= cmd_wdata;
                        end
                    end
                end
                S_ISSUE: begin
                    bus_clk_en <= 1'b0;
                    bus_wren   <= 1'b0;
                    if (cap_write) begin
                        state     <= S_RESP;
                        rsp_valid <= 1'b1;
                        rsp_error <= 1'b0;
                        rsp_rdata <= 32'd0;
                    end else begin
                        state   <= S_WAIT;
                        lat_cnt <= LAT_LAST;
                    end
                end
                S_WAIT: begin
                    if (lat_cnt == 3'd0) begin
                        state     <= S_RESP;
                        rsp_valid <= 1'b1;
                        rsp_error <= 1'b0;
                        rsp_rdata <= bus_data_read;
                    end else begin
                        lat_cnt <= lat_cnt - 3'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        state     <= S_IDLE;
                        rsp_valid <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/io_bus_master.md
IO_BUS_MASTER -- requirements
Module: io_bus_master

Interface
REQ-001 SHALL have parameter READ_LATENCY, default 1, giving the number of cycles between a read strobe and valid bus_data_read; legal range 1..7.
REQ-002 SHALL have parameter ADDR_W, default 32, giving the byte-address width of command and bus address.
REQ-003 SHALL have port clk, input, 1: single clock, all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-005 SHALL have port cmd_valid, input, 1: command offered.
REQ-006 SHALL have port cmd_ready, output, 1: command accepted when high with cmd_valid.
REQ-007 SHALL have port cmd_write, input, 1: 1 = write, 0 = read.
REQ-008 SHALL have port cmd_address, input, ADDR_W: byte address.
REQ-009 SHALL have port cmd_wdata, input, 32: write data.
REQ-010 SHALL have port rsp_valid, output, 1: response available.
REQ-011 SHALL have port rsp_ready, input, 1: response consumed when high with rsp_valid.
REQ-012 SHALL have port rsp_rdata, output, 32: read data; 0 for writes and errors.
REQ-013 SHALL have port rsp_error, output, 1: command rejected as misaligned.
REQ-014 SHALL have port bus_clk_en, output, 1: one-cycle transfer strobe to the peripheral responder.
REQ-015 SHALL have port bus_address, output, ADDR_W: byte address to the responder.
REQ-016 SHALL have port bus_data_write, output, 32: write data to the responder.
REQ-017 SHALL have port bus_wren, output, 1: write enable, qualified by bus_clk_en.
REQ-018 SHALL have port bus_data_read, input, 32: registered read data from the responder.

Function
REQ-019 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP.
REQ-020 SHALL drive cmd_ready=1 only in IDLE; a handshake (cmd_valid & cmd_ready) captures cmd_write/address/wdata into internal registers.
REQ-021 SHALL, on handshake with cmd_address[1:0]!=0, go IDLE->RESP with rsp_error=1, rsp_rdata=0, and no bus strobe.
REQ-022 SHALL, on an aligned handshake, go IDLE->ISSUE; in ISSUE assert bus_clk_en=1 for exactly one cycle with bus_address, bus_wren and bus_data_write from the captured command.
REQ-023 SHALL, for writes, go ISSUE->RESP with rsp_error=0, rsp_rdata=0.
REQ-024 SHALL, for reads, go ISSUE->WAIT, count READ_LATENCY cycles, and sample bus_data_read into rsp_rdata on the last WAIT cycle, then enter RESP.
REQ-025 SHALL hold rsp_valid=1 and rsp_rdata/rsp_error stable in RESP until rsp_ready=1, then return to IDLE on the next edge.
REQ-026 SHALL hold bus_clk_en=0 and bus_wren=0 in every state other than ISSUE; bus_address and bus_data_write hold their last values.
REQ-027 SHALL allow at most one outstanding transfer; with rsp_ready tied high, a write completes in 3 cycles and a read in 3+READ_LATENCY cycles from handshake to IDLE.
REQ-028 SHALL ignore cmd_valid and command-input changes outside IDLE.
REQ-029 SHALL ignore bus_data_read outside the sampling cycle of REQ-024.

Reset
REQ-030 SHALL, while rst_n=0 at a clock edge, enter IDLE and set bus_clk_en=0, bus_wren=0, bus_address=0, bus_data_write=0, rsp_valid=0, rsp_rdata=0, rsp_error=0, and the latency counter to 0; cmd_ready=1 follows from IDLE after reset release.
REQ-031 SHALL, on reset asserted mid-transfer (ISSUE, WAIT or RESP), abandon the transfer with no response and no further bus strobe.

Verification
REQ-032 SHALL verify a write: cmd write addr 0x4, wdata 0xA5 -> one cycle with bus_clk_en=1, bus_wren=1, bus_address=0x4, bus_data_write=0xA5; then rsp_valid with rsp_error=0, rsp_rdata=0.
REQ-033 SHALL verify a read: READ_LATENCY=1, cmd read addr 0x8, responder returns 0x0000000B -> rsp_rdata=0x0000000B, rsp_error=0, bus_wren=0 during the strobe.
REQ-034 SHALL verify a misaligned command: cmd addr 0x6 -> rsp_error=1, rsp_rdata=0, bus_clk_en never asserted.
REQ-035 SHALL verify backpressure: rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata stable, cmd_ready=0, no bus strobe; rsp_ready=1 -> IDLE next cycle.
REQ-036 SHALL verify reset during WAIT: rst_n=0 one cycle -> all outputs at reset values, no rsp_valid; a following read of addr 0x0 completes normally.
REQ-037 SHALL verify READ_LATENCY=3: bus_data_read is sampled exactly 3 cycles after the strobe, and a different value driven at 2 and 4 cycles is not captured.
